// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the instruction/data sram bus arbiter.
package sram_bus_arbiter_pkg;

    // sram-like transfer sizes
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Arbiter transaction phase
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    // Which master owns the transaction currently on the bus
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/sram_bus_arbiter_arb_grant.sv
// Grant selection: data wins by default, unless fetch has been passed over
// STARVE_LIMIT times in a row while it was waiting.
module sram_bus_arbiter_arb_grant #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inst_req,
    input  logic data_req,
    input  logic grant_en,
    output logic grant_inst,
    output logic grant_data
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    // Pick at most one master; grants only fire while the arbiter is idle
    always_comb begin
        starved    = inst_req && (starve_cnt == LIMIT);
        grant_data = grant_en && data_req && !starved;
        grant_inst = grant_en && inst_req && !grant_data;
    end

    // Count consecutive data grants taken while fetch was waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_inst) begin
            starve_cnt <= '0;
        end else if (grant_data) begin
            if (!inst_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like bus between the fetch and memory-stage masters.
// Handshake: a master holds *_req until its *_addr_ok pulse; *_data_ok is a
// single-cycle pulse carrying read data. On the bus side bus_req is held
// until bus_addr_ok, then the arbiter waits for bus_data_ok. One transaction
// is outstanding at a time and every bus output comes from registers.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output arb_state_t        dbg_state
);

    // Latched request; lives here because its widths follow the parameters
    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    sram_req_t  req_q;
    logic       grant_inst, grant_data;
    logic       addr_ok_any, data_ok_any;

    sram_bus_arbiter_arb_grant #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .data_req   (data_req),
        .grant_en   (state_q == ST_IDLE),
        .grant_inst (grant_inst),
        .grant_data (grant_data)
    );

    // State and owner registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Capture the winning master's request; fetch is always a word read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q <= '0;
        end else if (grant_data) begin
            req_q <= '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
        end else if (grant_inst) begin
            req_q <= '{wr: 1'b0, size: SIZE_WORD, addr: inst_addr, wdata: '0};
        end
    end

    // Next state plus the bus-side handshake events for the owner
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_req     = 1'b0;
        addr_ok_any = 1'b0;
        data_ok_any = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // bus_data_ok here is stray and deliberately ignored
                if (grant_data) begin
                    state_d = ST_ADDR;
                    owner_d = OWN_DATA;
                end else if (grant_inst) begin
                    state_d = ST_ADDR;
                    owner_d = OWN_INST;
                end
            end
            ST_ADDR: begin
                bus_req = 1'b1;
                if (bus_addr_ok) begin
                    addr_ok_any = 1'b1;
                    if (bus_data_ok) begin
                        data_ok_any = 1'b1;
                        state_d     = ST_IDLE;
                        owner_d     = OWN_NONE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    data_ok_any = 1'b1;
                    state_d     = ST_IDLE;
                    owner_d     = OWN_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // Route handshakes and read data to the owning master only
    always_comb begin
        inst_addr_ok = addr_ok_any && (owner_q == OWN_INST);
        inst_data_ok = data_ok_any && (owner_q == OWN_INST);
        data_addr_ok = addr_ok_any && (owner_q == OWN_DATA);
        data_data_ok = data_ok_any && (owner_q == OWN_DATA);
        inst_rdata   = (owner_q == OWN_INST) ? bus_rdata : '0;
        data_rdata   = (owner_q == OWN_DATA) ? bus_rdata : '0;
    end

    // Bus fields straight from the request register
    always_comb begin
        bus_wr    = req_q.wr;
        bus_size  = req_q.size;
        bus_addr  = req_q.addr;
        bus_wdata = req_q.wdata;
        busy      = (state_q != ST_IDLE);
        dbg_state = state_q;
    end

endmodule
